// File: rtl/gcd_job_dispatcher_if.sv
// Producer, GCD-core and consumer signals of the GCD job dispatcher, grouped as one bundle.
// slave is the dispatcher's view; master is the environment (producer, core, consumer).
interface gcd_job_dispatcher_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;

   logic             gcd_start;
   logic [WIDTH-1:0] gcd_a;
   logic [WIDTH-1:0] gcd_b;
   logic             gcd_done;
   logic [WIDTH-1:0] gcd_result;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_a;
   logic [WIDTH-1:0] out_b;
   logic [WIDTH-1:0] out_gcd;

   logic             busy;
   logic [7:0]       job_count;

   modport slave (
      input  in_valid, in_a, in_b, gcd_done, gcd_result, out_ready,
      output in_ready, gcd_start, gcd_a, gcd_b, out_valid, out_a, out_b, out_gcd,
             busy, job_count
   );

   modport master (
      output in_valid, in_a, in_b, gcd_done, gcd_result, out_ready,
      input  in_ready, gcd_start, gcd_a, gcd_b, out_valid, out_a, out_b, out_gcd,
             busy, job_count
   );
endinterface

// File: rtl/gcd_job_dispatcher.sv
// Queues operand pairs and runs them one at a time on the GCD core (start pulse 1 edge after pop, result on done);
// zero-operand pairs skip the core and are held on out_* one edge after pop. in_ready drops only when the FIFO is full.
module gcd_job_dispatcher #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   gcd_job_dispatcher_if.slave io
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } pair_t;

   typedef enum logic [2:0] {IDLE, ISSUE, GUARD, WAIT, HOLD} state_t;

   state_t           state;
   state_t           state_nxt;
   pair_t            mem [DEPTH];
   pair_t            head;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             push;
   logic             pop;
   logic             bypass;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] out_gcd;
   logic [7:0]       job_count;

   assign head        = mem[rd_ptr];
   assign io.in_ready = (count < FULL);
   assign push        = io.in_valid && io.in_ready;
   assign pop         = (state == IDLE) && (count != '0);
   assign bypass      = (head.a == '0) || (head.b == '0);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{a: io.in_a, b: io.in_b};
   end

   // Full is decided from the registered count, so a same-cycle pop never frees a slot early.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // GUARD exists so a done level left over from the previous job is never taken as this job's result.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pop) state_nxt = bypass ? HOLD : ISSUE;
         ISSUE:   state_nxt = GUARD;
         GUARD:   state_nxt = WAIT;
         WAIT:    if (io.gcd_done) state_nxt = HOLD;
         HOLD:    if (io.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a      <= '0;
         op_b      <= '0;
         out_gcd   <= '0;
         job_count <= '0;
      end else begin
         if (pop) begin
            op_a <= head.a;
            op_b <= head.b;
            if (bypass) out_gcd <= head.a | head.b;
         end
         if (state == WAIT && io.gcd_done)  out_gcd   <= io.gcd_result;
         if (state == HOLD && io.out_ready) job_count <= job_count + 8'd1;
      end
   end

   assign io.gcd_start = (state == ISSUE);
   assign io.gcd_a     = op_a;
   assign io.gcd_b     = op_b;
   assign io.out_valid = (state == HOLD);
   assign io.out_a     = op_a;
   assign io.out_b     = op_b;
   assign io.out_gcd   = out_gcd;
   assign io.busy      = (state != IDLE) || (count != '0);
   assign io.job_count = job_count;
endmodule

// File: tb/tb_gcd_job_dispatcher.sv
// Directed and randomized jobs through gcd_job_dispatcher with a behavioural GCD core and an in-order result model.
module tb_gcd_job_dispatcher;
   localparam int WIDTH = 16;
   localparam int DEPTH = 4;

   typedef struct {
      int a;
      int b;
   } job_t;

   logic clk;
   logic rst_n;

   int         tests = 0;
   int         fails = 0;
   job_t       exp_q[$];
   logic [7:0] exp_count = 0;
   int         rdy_mode = 1;
   bit         stale_mode = 0;
   int         lat_override = 0;

   int n_starts = 0;
   bit wide_start = 0;
   int unstable = 0;
   int job_a = 0;
   int job_b = 0;
   int wait_left = 0;
   int stale_left = 0;
   bit busy_core = 0;
   bit orphan = 0;
   bit prev_start = 0;

   gcd_job_dispatcher_if #(.WIDTH(WIDTH)) io ();

   gcd_job_dispatcher #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (io)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   function automatic int ref_gcd(input int a, input int b);
      int x = a;
      int y = b;
      int t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input int a, input int b);
      int guard = 0;
      io.in_valid = 1;
      io.in_a     = 16'(a);
      io.in_b     = 16'(b);
      while (!io.in_ready && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 1000) check("push_timeout", 32'(io.in_ready), 1);
      @(posedge clk);
      exp_q.push_back('{a, b});
      @(negedge clk);
      io.in_valid = 0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || io.busy) && n < 4000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 4000) check({tag, "_drain_timeout"}, 32'(exp_q.size()), 0);
   endtask

   // Behavioural core: done is a level that stays up until the next start; in stale mode it lingers two cycles longer.
   initial begin
      io.gcd_done   = 0;
      io.gcd_result = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) orphan = 1;
         if (io.gcd_start) begin
            n_starts++;
            if (prev_start) wide_start = 1;
            job_a     = 32'(io.gcd_a);
            job_b     = 32'(io.gcd_b);
            busy_core = 1;
            orphan    = 0;
            wait_left = (lat_override != 0) ? lat_override : int'($urandom_range(1, 5));
            if (stale_mode) begin
               stale_left = 2;
               if (wait_left < 3) wait_left = 3;
            end else begin
               stale_left  = 0;
               io.gcd_done = 0;
            end
         end else if (busy_core) begin
            if (!orphan && (io.gcd_a !== 16'(job_a) || io.gcd_b !== 16'(job_b))) unstable++;
            if (stale_left > 0) begin
               stale_left--;
               if (stale_left == 0) io.gcd_done = 0;
            end
            wait_left--;
            if (wait_left == 0) begin
               io.gcd_result = 16'(ref_gcd(job_a, job_b));
               io.gcd_done   = 1;
               busy_core     = 0;
            end
         end
         prev_start = io.gcd_start;
      end
   end

   // Consumer: drives out_ready, checks every handshake against the push-order model and hold stability.
   initial begin
      logic       hold_pend;
      logic [15:0] ha, hb, hg;
      job_t       e;
      hold_pend    = 0;
      ha           = 0;
      hb           = 0;
      hg           = 0;
      io.out_ready = 0;
      forever begin
         @(negedge clk);
         case (rdy_mode)
            0:       io.out_ready = 0;
            1:       io.out_ready = 1;
            default: io.out_ready = ($urandom_range(0, 1) != 0);
         endcase
         if (!rst_n) begin
            hold_pend = 0;
            exp_count = 0;
            exp_q.delete();
         end else begin
            if (hold_pend && io.out_valid) begin
               check("hold_out_a", 32'(io.out_a), 32'(ha));
               check("hold_out_b", 32'(io.out_b), 32'(hb));
               check("hold_out_gcd", 32'(io.out_gcd), 32'(hg));
            end
            if (io.out_valid && io.out_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_out", 32'(io.out_valid), 0);
               end else begin
                  e = exp_q.pop_front();
                  check("out_a", 32'(io.out_a), e.a);
                  check("out_b", 32'(io.out_b), e.b);
                  check("out_gcd", 32'(io.out_gcd), ref_gcd(e.a, e.b));
                  exp_count = exp_count + 8'd1;
               end
            end
            hold_pend = io.out_valid && !io.out_ready;
            ha = io.out_a;
            hb = io.out_b;
            hg = io.out_gcd;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
      $fatal(1, "watchdog");
   end

   initial begin
      int         s0;
      int         guard;
      logic [7:0] jc0;
      int         a;
      int         b;

      rst_n       = 1;
      io.in_valid = 0;
      io.in_a     = 0;
      io.in_b     = 0;
      #1 rst_n = 0;
      #1;
      check("rst_in_ready", 32'(io.in_ready), 1);
      check("rst_gcd_start", 32'(io.gcd_start), 0);
      check("rst_out_valid", 32'(io.out_valid), 0);
      check("rst_busy", 32'(io.busy), 0);
      check("rst_out_a", 32'(io.out_a), 0);
      check("rst_out_b", 32'(io.out_b), 0);
      check("rst_out_gcd", 32'(io.out_gcd), 0);
      check("rst_job_count", 32'(io.job_count), 0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(negedge clk);

      // Single core jobs with exact start and result timing
      s0 = n_starts;
      push(56, 14);
      @(negedge clk);
      check("start_after_pop", 32'(io.gcd_start), 1);
      @(negedge clk);
      check("start_one_cycle", 32'(io.gcd_start), 0);
      drain("single1");
      lat_override = 2;
      push(32, 48);
      repeat (3) @(negedge clk);
      check("valid_before_done", 32'(io.out_valid), 0);
      @(negedge clk);
      check("valid_on_done", 32'(io.out_valid), 1);
      check("gcd_32_48", 32'(io.out_gcd), 16);
      lat_override = 0;
      drain("single2");
      push(90, 45);
      drain("single3");
      push(49, 57);
      drain("single4");
      check("single_starts", n_starts - s0, 4);
      check("start_width", 32'(wide_start), 0);
      check("gcd_ab_stable", unstable, 0);
      check("single_job_count", 32'(io.job_count), 32'(exp_count));

      // Burst against a stalled consumer: one job popped, four queued fill the FIFO
      rdy_mode = 0;
      @(negedge clk);
      jc0 = exp_count;
      for (int i = 0; i < 5; i++) begin
         push($urandom_range(1, 500), $urandom_range(1, 500));
         if (i == 3) check("burst_ready_4", 32'(io.in_ready), 1);
         if (i == 4) check("burst_full_5", 32'(io.in_ready), 0);
      end
      repeat (20) @(negedge clk);
      check("burst_still_full", 32'(io.in_ready), 0);
      check("burst_holding", 32'(io.out_valid), 1);
      check("burst_busy", 32'(io.busy), 1);
      rdy_mode = 1;
      drain("burst");
      check("burst_job_count", 32'(io.job_count), 32'(jc0 + 8'd5));

      // Zero-operand bypass never touches the core
      s0 = n_starts;
      push(0, 25);
      @(negedge clk);
      check("bypass_valid", 32'(io.out_valid), 1);
      check("bypass_gcd_0_25", 32'(io.out_gcd), 25);
      push(18, 0);
      push(0, 0);
      drain("bypass");
      check("bypass_no_start", n_starts - s0, 0);

      // Stale done from the previous job must not complete the next one
      stale_mode = 1;
      push(56, 14);
      drain("stale1");
      rdy_mode = 0;
      push(7, 49);
      guard = 0;
      while (!io.out_valid && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check("stale_valid", 32'(io.out_valid), 1);
      check("stale_gcd", 32'(io.out_gcd), 7);
      rdy_mode = 1;
      drain("stale2");
      stale_mode = 0;

      // Randomized jobs with random consumer stalls and core latency
      rdy_mode = 2;
      for (int i = 0; i < 40; i++) begin
         a = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 2000));
         b = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 2000));
         push(a, b);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      rdy_mode = 1;
      drain("random");
      check("random_job_count", 32'(io.job_count), 32'(exp_count));

      // Reset while waiting on the core with two jobs queued
      lat_override = 20;
      push(56, 14);
      push(100, 75);
      push(9, 6);
      @(negedge clk);
      check("midrst_busy_before", 32'(io.busy), 1);
      rst_n = 0;
      #1;
      check("midrst_gcd_start", 32'(io.gcd_start), 0);
      check("midrst_out_valid", 32'(io.out_valid), 0);
      check("midrst_busy", 32'(io.busy), 0);
      check("midrst_in_ready", 32'(io.in_ready), 1);
      check("midrst_gcd_a", 32'(io.gcd_a), 0);
      check("midrst_out_gcd", 32'(io.out_gcd), 0);
      check("midrst_job_count", 32'(io.job_count), 0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      lat_override = 0;
      repeat (25) @(negedge clk);
      check("late_done_ignored", 32'(io.out_valid), 0);
      check("late_done_idle", 32'(io.busy), 0);
      push(12, 18);
      drain("after_rst");
      check("after_rst_job_count", 32'(io.job_count), 1);

      // 260 bypass jobs wrap the FIFO pointers and job_count
      @(negedge clk);
      rst_n = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      for (int k = 1; k <= 260; k++) push(0, k);
      drain("wrap");
      check("wrap_job_count", 32'(io.job_count), 4);
      check("wrap_model_count", 32'(io.job_count), 32'(exp_count));
      check("final_gcd_ab_stable", unstable, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
